// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding, header length and checksum width.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;

endpackage

// File: rtl/byte_packer.sv
// 8-to-32 big-endian assembler; word_ready_o pulses the cycle
// after the fourth byte of a word has been shifted in.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  cnt_o,
    output logic        word_ready_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        rdy_d  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            word_d = {word_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
            rdy_d  = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
        end
    end

    assign word_o       = word_q;
    assign cnt_o        = cnt_q;
    assign word_ready_o = rdy_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a length/payload/checksum frame
// into instruction-memory writes and holds the core in reset until valid.
module imem_loader
    import loader_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int LEN_W = 8 * HDR_BYTES;
    localparam int IW    = $clog2(DEPTH + 1);

    state_e              state_q, state_d;
    logic [LEN_W-9:0]    len_hi_q, len_hi_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [IW-1:0]       widx_q, widx_d;
    logic [CSUM_W-1:0]   acc_q, acc_d;

    logic                xfer;
    logic                clr;
    logic                pk_en;
    logic [1:0]          pk_cnt;
    logic [31:0]         pk_word;
    logic                pk_rdy;
    logic [LEN_W-1:0]    n_rx;
    logic                last_word;

    assign xfer      = in_valid && in_ready;
    assign pk_en     = xfer && (state_q == S_DATA);
    assign n_rx      = {len_hi_q, in_data};
    assign last_word = (LEN_W'(widx_q) == len_q - LEN_W'(1));

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .en_i         (pk_en),
        .byte_i       (in_data),
        .word_o       (pk_word),
        .cnt_o        (pk_cnt),
        .word_ready_o (pk_rdy)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        widx_d   = widx_q;
        acc_d    = acc_q;
        clr      = 1'b0;
        in_ready = 1'b0;
        if (pk_rdy) widx_d = widx_q + IW'(1);
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_LEN_HI;
                    clr      = 1'b1;
                    widx_d   = '0;
                    acc_d    = '0;
                    len_d    = '0;
                    len_hi_d = '0;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_d = n_rx;
                    if (n_rx == '0)
                        state_d = S_CHECK;
                    else if (n_rx > LEN_W'(DEPTH))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (xfer) begin
                    acc_d = acc_q ^ in_data;
                    if (pk_cnt == 2'd3 && last_word)
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                in_ready = 1'b1;
                if (xfer)
                    state_d = (in_data == acc_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            acc_q    <= acc_d;
        end
    end

    // The write strobe is the packer pulse; it lands in DATA or first CHECK cycle.
    assign mem_we    = pk_rdy;
    assign mem_wdata = pk_word;
    assign mem_addr  = W'({widx_q, 2'b00});
    assign cpu_hold  = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);

endmodule
